// File: rtl/univ_shift_reg_if.sv
// Control, data and status bundle for one univ_shift_reg bank.
interface univ_shift_reg_if #(
    parameter int unsigned WIDTH = 8
);
    logic             iPre;
    logic             iEnb;
    logic [2:0]       iMode;
    logic [WIDTH-1:0] iD;
    logic             iSdl;
    logic             iSdr;
    logic [WIDTH-1:0] oQ;
    logic [WIDTH-1:0] oQn;
    logic             oSo;
    logic             oTc;

    // Driver side: supplies controls, observes register state and flags.
    modport master (
        output iPre, iEnb, iMode, iD, iSdl, iSdr,
        input  oQ, oQn, oSo, oTc
    );

    // Register side.
    modport slave (
        input  iPre, iEnb, iMode, iD, iSdl, iSdr,
        output oQ, oQn, oSo, oTc
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold/load/shift/rotate/count with clear,
// preset, active-low enable, complement, serial-out and terminal-count flags.
module univ_shift_reg #(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic           iClk,
    input  logic           iClr,
    univ_shift_reg_if.slave bus
);
    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_UP   = 3'd6;
    localparam logic [2:0] MODE_DOWN = 3'd7;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next-state select: preset over enable over mode; unknown modes clear to 0.
    always_comb begin
        q_d = q_q;
        if (bus.iPre) begin
            q_d = '1;
        end else if (!bus.iEnb) begin
            case (bus.iMode)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: q_d = bus.iD;
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], bus.iSdl};
                MODE_SHR:  q_d = {bus.iSdr, q_q[WIDTH-1:1]};
                MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_UP:   q_d = q_q + WIDTH'(1);
                MODE_DOWN: q_d = q_q - WIDTH'(1);
                default:   q_d = '0;
            endcase
        end
    end

    // State register; synchronous clear takes priority over everything.
    always_ff @(posedge iClk) begin
        if (iClr) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.oQ  = q_q;
    assign bus.oQn = ~q_q;
    // Serial out follows the bit about to leave in left-moving modes.
    assign bus.oSo = ((bus.iMode == MODE_SHL) || (bus.iMode == MODE_ROL)) ? q_q[WIDTH-1] : q_q[0];
    // Terminal count flags the cycle before a wrap, for cascading into ~iEnb.
    assign bus.oTc = ~bus.iEnb & (((bus.iMode == MODE_UP) & (&q_q)) |
                                  ((bus.iMode == MODE_DOWN) & (~|q_q)));
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: main instance plus a two-stage cascade.
module tb_univ_shift_reg;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic clr;
    logic cclr;
    int   checks;
    int   failures;

    univ_shift_reg_if #(.WIDTH(WIDTH)) dut_if ();
    univ_shift_reg_if #(.WIDTH(WIDTH)) lo_if ();
    univ_shift_reg_if #(.WIDTH(WIDTH)) hi_if ();

    univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'hA5)) dut (
        .iClk (clk),
        .iClr (clr),
        .bus  (dut_if.slave)
    );

    univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) u_lo (
        .iClk (clk),
        .iClr (cclr),
        .bus  (lo_if.slave)
    );

    univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) u_hi (
        .iClk (clk),
        .iClr (cclr),
        .bus  (hi_if.slave)
    );

    // High stage advances only when the low stage is about to wrap.
    assign hi_if.iEnb = ~lo_if.oTc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic pre, input logic enb, input logic [2:0] mode,
                           input logic [7:0] d, input logic sdl, input logic sdr);
        dut_if.iPre  = pre;
        dut_if.iEnb  = enb;
        dut_if.iMode = mode;
        dut_if.iD    = d;
        dut_if.iSdl  = sdl;
        dut_if.iSdr  = sdr;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clr      = 1'b1;
        cclr     = 1'b1;
        set_ctl(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        lo_if.iPre = 1'b0; lo_if.iEnb = 1'b0; lo_if.iMode = 3'd0;
        lo_if.iD = 8'h00; lo_if.iSdl = 1'b0; lo_if.iSdr = 1'b0;
        hi_if.iPre = 1'b0; hi_if.iMode = 3'd0;
        hi_if.iD = 8'h00; hi_if.iSdl = 1'b0; hi_if.iSdr = 1'b0;
        #2;

        // Reset and clear-over-preset
        tick();
        check("reset_q", 32'(dut_if.oQ), 32'h A5);
        check("reset_qn", 32'(dut_if.oQn), 32'h5A);
        dut_if.iPre = 1'b1;
        tick();
        check("clr_over_pre", 32'(dut_if.oQ), 32'hA5);
        clr  = 1'b0;
        cclr = 1'b0;

        // Load then hold while disabled
        set_ctl(1'b0, 1'b0, 3'd1, 8'h3C, 1'b0, 1'b0);
        tick();
        check("load_3c", 32'(dut_if.oQ), 32'h3C);
        set_ctl(1'b0, 1'b1, 3'd1, 8'hFF, 1'b0, 1'b0);
        tick();
        check("enb_hold", 32'(dut_if.oQ), 32'h3C);
        set_ctl(1'b0, 1'b0, 3'd0, 8'hFF, 1'b1, 1'b1);
        tick();
        check("mode_hold", 32'(dut_if.oQ), 32'h3C);

        // Shift left from 81
        set_ctl(1'b0, 1'b0, 3'd1, 8'h81, 1'b0, 1'b0);
        tick();
        set_ctl(1'b0, 1'b0, 3'd2, 8'h00, 1'b0, 1'b1);
        #1;
        check("shl_so", 32'(dut_if.oSo), 32'h1);
        tick();
        check("shl_q", 32'(dut_if.oQ), 32'h02);

        // Rotate right from 81
        set_ctl(1'b0, 1'b0, 3'd1, 8'h81, 1'b0, 1'b0);
        tick();
        set_ctl(1'b0, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0);
        tick();
        check("ror_q", 32'(dut_if.oQ), 32'hC0);

        // Shift right from 81 with sdr=1
        set_ctl(1'b0, 1'b0, 3'd1, 8'h81, 1'b0, 1'b0);
        tick();
        set_ctl(1'b0, 1'b0, 3'd3, 8'h00, 1'b1, 1'b1);
        #1;
        check("shr_so", 32'(dut_if.oSo), 32'h1);
        tick();
        check("shr_q", 32'(dut_if.oQ), 32'hC0);

        // Rotate left from 81
        set_ctl(1'b0, 1'b0, 3'd1, 8'h81, 1'b0, 1'b0);
        tick();
        set_ctl(1'b0, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0);
        tick();
        check("rol_q", 32'(dut_if.oQ), 32'h03);

        // Up-count wrap
        set_ctl(1'b0, 1'b0, 3'd1, 8'hFE, 1'b0, 1'b0);
        tick();
        set_ctl(1'b0, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0);
        #1;
        check("up_tc_fe", 32'(dut_if.oTc), 32'h0);
        tick();
        check("up_ff", 32'(dut_if.oQ), 32'hFF);
        check("up_tc_ff", 32'(dut_if.oTc), 32'h1);

        // Disabled at all ones: no terminal count, no wrap
        dut_if.iEnb = 1'b1;
        #1;
        check("enb_tc", 32'(dut_if.oTc), 32'h0);
        tick();
        check("enb_nowrap", 32'(dut_if.oQ), 32'hFF);
        dut_if.iEnb = 1'b0;
        tick();
        check("up_wrap", 32'(dut_if.oQ), 32'h00);
        check("up_tc_00", 32'(dut_if.oTc), 32'h0);

        // Down-count wrap
        dut_if.iMode = 3'd7;
        #1;
        check("down_tc", 32'(dut_if.oTc), 32'h1);
        tick();
        check("down_wrap", 32'(dut_if.oQ), 32'hFF);
        check("down_tc_ff", 32'(dut_if.oTc), 32'h0);

        // Mid-count clear then resume
        set_ctl(1'b0, 1'b0, 3'd1, 8'h10, 1'b0, 1'b0);
        tick();
        dut_if.iMode = 3'd6;
        tick();
        check("count_11", 32'(dut_if.oQ), 32'h11);
        clr = 1'b1;
        tick();
        check("mid_clr", 32'(dut_if.oQ), 32'hA5);
        clr = 1'b0;
        tick();
        check("resume", 32'(dut_if.oQ), 32'hA6);

        // Preset, also overriding the disable
        set_ctl(1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
        tick();
        check("preset", 32'(dut_if.oQ), 32'hFF);
        check("preset_qn", 32'(dut_if.oQn), 32'h00);

        // Cascade: load 00FF, one edge to 0100, then 0101
        lo_if.iMode = 3'd1; lo_if.iD = 8'hFF;
        hi_if.iMode = 3'd1; hi_if.iD = 8'h00;
        tick();
        check("casc_load", 32'({hi_if.oQ, lo_if.oQ}), 32'h00FF);
        lo_if.iMode = 3'd6;
        hi_if.iMode = 3'd6;
        #1;
        check("casc_tc", 32'(lo_if.oTc), 32'h1);
        tick();
        check("casc_carry", 32'({hi_if.oQ, lo_if.oQ}), 32'h0100);
        tick();
        check("casc_nocarry", 32'({hi_if.oQ, lo_if.oQ}), 32'h0101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
